// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU arbiter: opcode/state enums,
// the legal-operation check and the post-response drain length.
package alu_arb_pkg;

   localparam int DRAIN_CYC = 4;
   localparam logic [1:0] OPT_ALU = 2'b11;

   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_ADD    = 4'd1,
      OP_SUB    = 4'd2,
      OP_AND    = 4'd3,
      OP_MUL    = 4'd4,
      OP_OR     = 4'd5,
      OP_XOR    = 4'd6,
      OP_SHL    = 4'd7,
      OP_SHR    = 4'd8,
      OP_MULSUB = 4'd9,
      OP_MULADD = 4'd10,
      OP_SQR    = 4'd11,
      OP_MACC   = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP,
      ST_DRAIN
   } state_e;

   // Only ALU-type requests with an opcode the shared ALU implements are sent to it.
   function automatic logic op_legal(input logic [3:0] op, input logic [1:0] op_type);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_MUL, OP_SHL, OP_SHR,
         OP_MULSUB, OP_MULADD, OP_SQR, OP_MACC: ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok && (op_type == OPT_ALU);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side signal bundle of the ALU arbiter.
// slave = arbiter view, master = requesters plus ALU view.
interface alu_arbiter_if #(parameter int NREQ = 4);

   logic [NREQ-1:0]      req;
   logic [NREQ-1:0][3:0] req_op;
   logic [NREQ-1:0][1:0] req_op_type;
   logic [NREQ-1:0][7:0] req_b;
   logic [NREQ-1:0][7:0] req_c;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      rsp_valid;
   logic [7:0]           rsp_data;
   logic                 rsp_err;
   logic [3:0]           alu_op;
   logic [1:0]           alu_op_type;
   logic [7:0]           alu_b;
   logic [7:0]           alu_c;
   logic                 alu_start;
   logic [7:0]           alu_a;
   logic                 alu_done;

   modport slave (
      input  req, req_op, req_op_type, req_b, req_c, alu_a, alu_done,
      output gnt, rsp_valid, rsp_data, rsp_err,
             alu_op, alu_op_type, alu_b, alu_c, alu_start
   );

   modport master (
      output req, req_op, req_op_type, req_b, req_c, alu_a, alu_done,
      input  gnt, rsp_valid, rsp_data, rsp_err,
             alu_op, alu_op_type, alu_b, alu_c, alu_start
   );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ, returned one-hot (all zero when nothing requests).
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] owner
);

   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      owner = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (!found && req[idx]) begin
            owner[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among NREQ requesters.
// Optional BUSY watchdog is built when ALU_ARB_TIMEOUT_EN is defined.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   alu_arbiter_if.slave  bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int DW = $clog2(DRAIN_CYC);

   state_e          state, state_nx;
   logic [PW-1:0]   rr_ptr, ptr_nx, sel_idx;
   logic [NREQ-1:0] pick, owner, owner_nx;
   logic [NREQ-1:0] gnt, gnt_nx, rsp_valid, rsp_valid_nx;
   logic [DW-1:0]   drain_cnt, drain_nx;
   logic [7:0]      rsp_data, rsp_data_nx;
   logic            rsp_err, rsp_err_nx;
   logic            alu_start, alu_start_nx;
   logic [3:0]      alu_op, alu_op_nx;
   logic [1:0]      alu_op_type, alu_op_type_nx;
   logic [7:0]      alu_b, alu_b_nx, alu_c, alu_c_nx;
`ifdef ALU_ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0]   wdog, wdog_nx;
`endif

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (bus.req),
      .ptr   (rr_ptr),
      .owner (pick)
   );

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (pick[i]) sel_idx = PW'(i);
   end

   always_comb begin
      state_nx       = state;
      ptr_nx         = rr_ptr;
      owner_nx       = owner;
      drain_nx       = drain_cnt;
      gnt_nx         = '0;
      rsp_valid_nx   = '0;
      rsp_data_nx    = rsp_data;
      rsp_err_nx     = rsp_err;
      alu_start_nx   = 1'b0;
      alu_op_nx      = alu_op;
      alu_op_type_nx = alu_op_type;
      alu_b_nx       = alu_b;
      alu_c_nx       = alu_c;
`ifdef ALU_ARB_TIMEOUT_EN
      wdog_nx        = wdog;
`endif
      case (state)
         ST_IDLE: begin
            if (|bus.req) begin
               owner_nx       = pick;
               gnt_nx         = pick;
               ptr_nx         = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
               alu_op_nx      = bus.req_op[sel_idx];
               alu_op_type_nx = bus.req_op_type[sel_idx];
               alu_b_nx       = bus.req_b[sel_idx];
               alu_c_nx       = bus.req_c[sel_idx];
               if (op_legal(bus.req_op[sel_idx], bus.req_op_type[sel_idx])) begin
                  state_nx     = ST_BUSY;
                  alu_start_nx = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
                  wdog_nx      = '0;
`endif
               end else begin
                  // Rejected ops answer immediately, alongside the grant.
                  state_nx     = ST_RESP;
                  rsp_valid_nx = pick;
                  rsp_err_nx   = 1'b1;
                  rsp_data_nx  = '0;
               end
            end
         end
         ST_BUSY: begin
            alu_start_nx = 1'b1;
            if (bus.alu_done) begin
               state_nx     = ST_RESP;
               alu_start_nx = 1'b0;
               rsp_valid_nx = owner;
               rsp_data_nx  = bus.alu_a;
               rsp_err_nx   = 1'b0;
            end
`ifdef ALU_ARB_TIMEOUT_EN
            else if (wdog == WW'(TIMEOUT - 1)) begin
               state_nx     = ST_RESP;
               alu_start_nx = 1'b0;
               rsp_valid_nx = owner;
               rsp_data_nx  = '0;
               rsp_err_nx   = 1'b1;
            end else begin
               wdog_nx = wdog + 1'b1;
            end
`endif
         end
         ST_RESP: begin
            state_nx = ST_DRAIN;
            drain_nx = '0;
         end
         ST_DRAIN: begin
            // Keep the ALU idle long enough for any stale done pulse to flush.
            if (drain_cnt == DW'(DRAIN_CYC - 1)) state_nx = ST_IDLE;
            else                                 drain_nx = drain_cnt + 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         owner       <= '0;
         drain_cnt   <= '0;
         gnt         <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         alu_start   <= 1'b0;
         alu_op      <= '0;
         alu_op_type <= '0;
         alu_b       <= '0;
         alu_c       <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
         wdog        <= '0;
`endif
      end else begin
         state       <= state_nx;
         rr_ptr      <= ptr_nx;
         owner       <= owner_nx;
         drain_cnt   <= drain_nx;
         gnt         <= gnt_nx;
         rsp_valid   <= rsp_valid_nx;
         rsp_data    <= rsp_data_nx;
         rsp_err     <= rsp_err_nx;
         alu_start   <= alu_start_nx;
         alu_op      <= alu_op_nx;
         alu_op_type <= alu_op_type_nx;
         alu_b       <= alu_b_nx;
         alu_c       <= alu_c_nx;
`ifdef ALU_ARB_TIMEOUT_EN
         wdog        <= wdog_nx;
`endif
      end
   end

   assign bus.gnt         = gnt;
   assign bus.rsp_valid   = rsp_valid;
   assign bus.rsp_data    = rsp_data;
   assign bus.rsp_err     = rsp_err;
   assign bus.alu_start   = alu_start;
   assign bus.alu_op      = alu_op;
   assign bus.alu_op_type = alu_op_type;
   assign bus.alu_b       = alu_b;
   assign bus.alu_c       = alu_c;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
// Watchdog case is included when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_arbiter;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   logic       alu_en;
   logic       done_force;
   logic [7:0] alu_cnt;

   alu_arbiter_if #(.NREQ(4)) bus ();

   alu_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] b, input logic [7:0] c);
      case (op)
         4'd1:    return b + c;
         4'd2:    return b - c;
         4'd3:    return b & c;
         4'd4:    return b * c;
         4'd7:    return b << c[2:0];
         4'd8:    return b >> c[2:0];
         4'd9:    return b * c - b;
         4'd10:   return b * c + b;
         4'd11:   return b * b;
         4'd12:   return b * c + c;
         default: return 8'd0;
      endcase
   endfunction

   // Behavioural ALU: fast ops finish in the 2nd start cycle, multiplies in the 5th.
   logic slow_op;
   assign slow_op      = (bus.alu_op == 4'd4) || (bus.alu_op >= 4'd9);
   assign bus.alu_a    = alu_f(bus.alu_op, bus.alu_b, bus.alu_c);
   assign bus.alu_done = done_force ||
                         (alu_en && bus.alu_start && (alu_cnt == (slow_op ? 8'd4 : 8'd1)));

   always @(posedge clk) alu_cnt <= bus.alu_start ? alu_cnt + 8'd1 : 8'd0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.req = '0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Single requester transaction; latency counted from the cycle req is first seen.
   task automatic run_txn(input logic [1:0] idx, input logic [3:0] op, input logic [1:0] ot,
                          input logic [7:0] b, input logic [7:0] c,
                          input int exp_lat, input logic [7:0] exp_data, input logic exp_err);
      logic [3:0] oh;
      int         lat;
      logic       started;
      oh                   = 4'b0001 << idx;
      bus.req_op[idx]      = op;
      bus.req_op_type[idx] = ot;
      bus.req_b[idx]       = b;
      bus.req_c[idx]       = c;
      bus.req              = oh;
      started              = 1'b0;
      lat                  = 0;
      step();
      check_eq("gnt", bus.gnt, oh);
      bus.req              = '0;
      bus.req_b[idx]       = ~b;
      bus.req_c[idx]       = ~c;
      bus.req_op[idx]      = 4'd0;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) step();
         if (bus.alu_start) started = 1'b1;
         if (bus.rsp_valid != '0) begin
            lat = k;
            break;
         end
      end
      check_eq("rsp_latency", lat, exp_lat);
      check_eq("rsp_valid", bus.rsp_valid, oh);
      check_eq("rsp_data", bus.rsp_data, exp_data);
      check_eq("rsp_err", bus.rsp_err, exp_err);
      for (int d = 0; d < 4; d++) begin
         step();
         if (bus.alu_start) started = 1'b1;
         check_eq("drain_quiet", {bus.alu_start, bus.rsp_valid, bus.gnt}, 9'd0);
      end
      check_eq("start_seen", started, (exp_lat > 1));
      step();
   endtask

   initial begin
      reset_n          = 1'b0;
      alu_en           = 1'b1;
      done_force       = 1'b0;
      bus.req          = '0;
      bus.req_op       = '0;
      bus.req_op_type  = '0;
      bus.req_b        = '0;
      bus.req_c        = '0;

      do_reset();
      check_eq("reset_outputs",
               {bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.alu_start,
                bus.alu_op, bus.alu_op_type, bus.alu_b, bus.alu_c}, 37'd0);

      run_txn(2'd1, 4'd1, 2'b11, 8'd5, 8'd3, 3, 8'd8, 1'b0);
      run_txn(2'd0, 4'd4, 2'b11, 8'd7, 8'd6, 6, 8'd42, 1'b0);
      run_txn(2'd2, 4'd9, 2'b11, 8'd3, 8'd4, 6, 8'd9, 1'b0);
      run_txn(2'd3, 4'd5, 2'b11, 8'd1, 8'd2, 1, 8'd0, 1'b1);
      run_txn(2'd1, 4'd2, 2'b11, 8'd9, 8'd4, 3, 8'd5, 1'b0);
      run_txn(2'd3, 4'd7, 2'b11, 8'd3, 8'd2, 3, 8'd12, 1'b0);
      run_txn(2'd2, 4'd1, 2'b10, 8'd5, 8'd3, 1, 8'd0, 1'b1);

      // alu_done while idle must not produce anything
      done_force = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("done_idle_ignored", {bus.rsp_valid, bus.alu_start}, 5'd0);
      end
      done_force = 1'b0;

      // Simultaneous req[0]/req[2] from pointer 0
      do_reset();
      bus.req_op[0] = 4'd1; bus.req_op_type[0] = 2'b11; bus.req_b[0] = 8'd1; bus.req_c[0] = 8'd2;
      bus.req_op[2] = 4'd2; bus.req_op_type[2] = 2'b11; bus.req_b[2] = 8'd9; bus.req_c[2] = 8'd4;
      bus.req = 4'b0101;
      step();
      check_eq("rr_first_gnt", bus.gnt, 4'b0001);
      bus.req = 4'b0100;
      step();
      step();
      check_eq("rr_first_rsp", {bus.rsp_valid, bus.rsp_data}, {4'b0001, 8'd3});
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("rr_wait_no_gnt", bus.gnt, 4'b0000);
      end
      step();
      check_eq("rr_second_gnt", bus.gnt, 4'b0100);
      bus.req = '0;
      step();
      step();
      check_eq("rr_second_rsp", {bus.rsp_valid, bus.rsp_data}, {4'b0100, 8'd5});
      repeat (5) step();
      bus.req_op[3] = 4'd1; bus.req_op_type[3] = 2'b11; bus.req_b[3] = 8'd2; bus.req_c[3] = 8'd2;
      bus.req = 4'b1001;
      step();
      check_eq("rr_ptr_3_gnt", bus.gnt, 4'b1000);
      bus.req = '0;
      step();
      step();
      check_eq("rr_ptr_3_rsp", {bus.rsp_valid, bus.rsp_data}, {4'b1000, 8'd4});
      repeat (5) step();
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("dropped_req_ignored", bus.gnt, 4'b0000);
      end

      // Reset in the middle of BUSY aborts silently
      alu_en = 1'b0;
      bus.req_op[1] = 4'd1; bus.req_op_type[1] = 2'b11; bus.req_b[1] = 8'd5; bus.req_c[1] = 8'd3;
      bus.req = 4'b0010;
      step();
      bus.req = '0;
      step();
      step();
      check_eq("busy_start", bus.alu_start, 1'b1);
      reset_n = 1'b0;
      step();
      check_eq("midbusy_reset_outputs",
               {bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.alu_start,
                bus.alu_op, bus.alu_op_type, bus.alu_b, bus.alu_c}, 37'd0);
      reset_n = 1'b1;
      alu_en  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("abort_no_rsp", {bus.rsp_valid, bus.alu_start}, 5'd0);
      end
      bus.req_op[3] = 4'd1; bus.req_op_type[3] = 2'b11;
      bus.req = 4'b1010;
      step();
      check_eq("post_reset_ptr0", bus.gnt, 4'b0010);
      bus.req = '0;
      repeat (10) step();

`ifdef ALU_ARB_TIMEOUT_EN
      alu_en = 1'b0;
      run_txn(2'd0, 4'd1, 2'b11, 8'd5, 8'd3, 17, 8'd0, 1'b1);
      alu_en = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=%0d expected=%0d", 1, 0);
      $fatal(1, "bench timed out");
   end

endmodule
